// File: rtl/fp_result_pack.sv
// fp_result_pack: corrects rounding carry, clamps to inf/zero, packs an IEEE-754 single word
// and hands it downstream through a 2-entry skid buffer with sticky flags and a result counter.
module fp_result_pack #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_zero,
    input  logic               in_sign,
    input  logic [9:0]         in_exponent,
    input  logic [23:0]        in_mantissa,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_result,
    output logic               out_overflow,
    output logic               out_underflow,
    output logic               sticky_overflow,
    output logic               sticky_underflow,
    input  logic               clear_flags,
    output logic [COUNT_W-1:0] result_count
);
    logic signed [10:0] adjExp;
    logic               isOvf;
    logic               isUnf;
    logic [31:0]        packWord;
    logic [33:0]        entry [2];
    logic [33:0]        head;
    logic               rdPtr;
    logic               wrPtr;
    logic [1:0]         occ;
    logic [1:0]         occNext;
    logic               readyReg;
    logic               push;
    logic               pop;

    always_comb begin
        adjExp   = $signed({in_exponent[9], in_exponent}) + $signed({10'd0, in_mantissa[23]});
        isOvf    = !in_zero && adjExp >= 11'sd255;
        isUnf    = !in_zero && !isOvf && adjExp <= 11'sd0;
        packWord = in_zero ? 32'd0
                 : isOvf   ? {in_sign, 8'hFF, 23'd0}
                 : isUnf   ? {in_sign, 31'd0}
                 : {in_sign, adjExp[7:0], in_mantissa[23] ? 23'd0 : in_mantissa[22:0]};
    end

    assign in_ready  = readyReg;
    assign out_valid = occ != 2'd0;
    assign push      = in_valid & readyReg;
    assign pop       = out_valid & out_ready;
    assign occNext   = occ + {1'b0, push} - {1'b0, pop};
    // Gating on out_valid keeps discarded entries from showing after a reset.
    assign head          = out_valid ? entry[rdPtr] : 34'd0;
    assign out_overflow  = head[33];
    assign out_underflow = head[32];
    assign out_result    = head[31:0];

    always_ff @(posedge clk) begin
        if (push) entry[wrPtr] <= {isOvf, isUnf, packWord};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ              <= 2'd0;
            rdPtr            <= 1'b0;
            wrPtr            <= 1'b0;
            readyReg         <= 1'b0;
            sticky_overflow  <= 1'b0;
            sticky_underflow <= 1'b0;
            result_count     <= '0;
        end else begin
            occ              <= occNext;
            readyReg         <= occNext != 2'd2;
            wrPtr            <= wrPtr ^ push;
            rdPtr            <= rdPtr ^ pop;
            sticky_overflow  <= (push & isOvf) | (sticky_overflow & !clear_flags);
            sticky_underflow <= (push & isUnf) | (sticky_underflow & !clear_flags);
            result_count     <= clear_flags ? '0
                              : (pop && result_count != '1) ? result_count + 1'b1
                              : result_count;
        end
    end
endmodule

// File: tb/tb_fp_result_pack.sv
// tb_fp_result_pack: scoreboard bench; expectations queued at acceptance, checked at delivery.
module tb_fp_result_pack;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic        in_zero = 0;
    logic        in_sign = 0;
    logic [9:0]  in_exponent = 0;
    logic [23:0] in_mantissa = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        sticky_overflow;
    logic        sticky_underflow;
    logic        clear_flags = 0;
    logic [3:0]  result_count;

    int total = 0;
    int bad = 0;
    logic [33:0] q[$];
    logic [33:0] e;

    fp_result_pack #(.COUNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_zero(in_zero), .in_sign(in_sign), .in_exponent(in_exponent),
        .in_mantissa(in_mantissa), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_overflow(out_overflow), .out_underflow(out_underflow),
        .sticky_overflow(sticky_overflow), .sticky_underflow(sticky_underflow),
        .clear_flags(clear_flags), .result_count(result_count)
    );

    always #5 clk = ~clk;

    function automatic logic [33:0] model(input logic z, input logic s, input logic [9:0] ex,
                                          input logic [23:0] m);
        int x = (ex >= 10'd512) ? int'(ex) - 1024 : int'(ex);
        x += int'(m[23]);
        if (z) return 34'd0;
        if (x >= 255) return {2'b10, s, 8'hFF, 23'd0};
        if (x <= 0) return {2'b01, s, 31'd0};
        return {2'b00, s, x[7:0], m[23] ? 23'd0 : m[22:0]};
    endfunction

    // Inputs change on the falling edge; expectation is queued only if this cycle accepts.
    task automatic drive(input logic z, input logic s, input logic [9:0] ex,
                         input logic [23:0] m, input logic [33:0] x);
        in_valid = 1; in_zero = z; in_sign = s; in_exponent = ex; in_mantissa = m;
        if (in_ready) q.push_back(x);
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        total++; if (out_valid !== 0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        total++; if (out_result !== 0) begin bad++; $display("FAIL rst_result: got %h want 0", out_result); end
        total++; if ({out_overflow, out_underflow} !== 2'b00) begin bad++; $display("FAIL rst_flags: got %b want 00", {out_overflow, out_underflow}); end
        total++; if ({sticky_overflow, sticky_underflow} !== 2'b00) begin bad++; $display("FAIL rst_sticky: got %b want 00", {sticky_overflow, sticky_underflow}); end
        total++; if (result_count !== 0) begin bad++; $display("FAIL rst_count: got %0d want 0", result_count); end
        total++; if (in_ready !== 0) begin bad++; $display("FAIL rst_ready: got %b want 0", in_ready); end
        rst_n = 1;
        @(negedge clk);
        total++; if (in_ready !== 1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_normal();
        out_ready = 1;
        drive(0, 0, 10'd128, 24'h000000, {2'b00, 32'h40000000});
        @(negedge clk);
        in_valid = 0;
        e = q.size() ? q.pop_front() : 'x;
        total++; if (!out_valid || {out_overflow, out_underflow, out_result} !== e) begin bad++; $display("FAIL normal: got v=%b %h want %h", out_valid, {out_overflow, out_underflow, out_result}, e); end
        @(negedge clk);
        total++; if (out_valid !== 0) begin bad++; $display("FAIL normal_drain: got %b want 0", out_valid); end
        total++; if (result_count !== 1) begin bad++; $display("FAIL normal_count: got %0d want 1", result_count); end
    endtask

    task automatic test_carry();
        out_ready = 1;
        drive(0, 0, 10'd127, 24'h800000, {2'b00, 32'h40000000});
        @(negedge clk);
        e = q.size() ? q.pop_front() : 'x;
        total++; if (!out_valid || {out_overflow, out_underflow, out_result} !== e) begin bad++; $display("FAIL carry_norm: got v=%b %h want %h", out_valid, {out_overflow, out_underflow, out_result}, e); end
        drive(0, 0, 10'd254, 24'h800000, {2'b10, 32'h7F800000});
        @(negedge clk);
        in_valid = 0;
        e = q.size() ? q.pop_front() : 'x;
        total++; if (!out_valid || {out_overflow, out_underflow, out_result} !== e) begin bad++; $display("FAIL carry_ovf: got v=%b %h want %h", out_valid, {out_overflow, out_underflow, out_result}, e); end
        total++; if (sticky_overflow !== 1) begin bad++; $display("FAIL carry_sticky: got %b want 1", sticky_overflow); end
        @(negedge clk);
        total++; if (result_count !== 3) begin bad++; $display("FAIL carry_count: got %0d want 3", result_count); end
    endtask

    task automatic test_underflow_zero();
        out_ready = 1;
        drive(0, 1, 10'h3FF, 24'h7FFFFF, {2'b01, 32'h80000000});
        @(negedge clk);
        e = q.size() ? q.pop_front() : 'x;
        total++; if (!out_valid || {out_overflow, out_underflow, out_result} !== e) begin bad++; $display("FAIL underflow: got v=%b %h want %h", out_valid, {out_overflow, out_underflow, out_result}, e); end
        drive(1, 1, 10'd300, 24'h123456, {2'b00, 32'h00000000});
        @(negedge clk);
        in_valid = 0; in_zero = 0;
        e = q.size() ? q.pop_front() : 'x;
        total++; if (!out_valid || {out_overflow, out_underflow, out_result} !== e) begin bad++; $display("FAIL zero: got v=%b %h want %h", out_valid, {out_overflow, out_underflow, out_result}, e); end
        total++; if (sticky_underflow !== 1) begin bad++; $display("FAIL uf_sticky: got %b want 1", sticky_underflow); end
        @(negedge clk);
        total++; if (result_count !== 5) begin bad++; $display("FAIL uf_count: got %0d want 5", result_count); end
    endtask

    task automatic test_clear();
        out_ready = 1;
        clear_flags = 1;
        @(negedge clk);
        total++; if ({sticky_overflow, sticky_underflow} !== 2'b00) begin bad++; $display("FAIL clear_lone: got %b want 00", {sticky_overflow, sticky_underflow}); end
        total++; if (result_count !== 0) begin bad++; $display("FAIL clear_count: got %0d want 0", result_count); end
        drive(0, 1, 10'd300, 24'h000001, {2'b10, 32'hFF800000});
        @(negedge clk);
        in_valid = 0;
        total++; if (sticky_overflow !== 1) begin bad++; $display("FAIL clear_set_wins: got %b want 1", sticky_overflow); end
        e = q.size() ? q.pop_front() : 'x;
        total++; if (!out_valid || {out_overflow, out_underflow, out_result} !== e) begin bad++; $display("FAIL clear_ovf: got v=%b %h want %h", out_valid, {out_overflow, out_underflow, out_result}, e); end
        @(negedge clk);
        clear_flags = 0;
        total++; if (sticky_overflow !== 0) begin bad++; $display("FAIL clear_later: got %b want 0", sticky_overflow); end
        total++; if (result_count !== 0) begin bad++; $display("FAIL clear_deliver_count: got %0d want 0", result_count); end
    endtask

    task automatic test_backpressure();
        out_ready = 0;
        drive(0, 0, 10'd100, 24'h0000AA, {2'b00, 1'b0, 8'd100, 23'h0000AA});
        @(negedge clk);
        drive(0, 1, 10'd200, 24'h0000BB, {2'b00, 1'b1, 8'd200, 23'h0000BB});
        @(negedge clk);
        total++; if (in_ready !== 0) begin bad++; $display("FAIL bp_full: got %b want 0", in_ready); end
        drive(0, 0, 10'd50, 24'h0000CC, {2'b00, 1'b0, 8'd50, 23'h0000CC});
        @(negedge clk);
        total++; if (in_ready !== 0) begin bad++; $display("FAIL bp_hold: got %b want 0", in_ready); end
        total++; if (!out_valid || {out_overflow, out_underflow, out_result} !== q[0]) begin bad++; $display("FAIL bp_stable: got v=%b %h want %h", out_valid, {out_overflow, out_underflow, out_result}, q[0]); end
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            e = q.size() ? q.pop_front() : 'x;
            total++; if (!out_valid || {out_overflow, out_underflow, out_result} !== e) begin bad++; $display("FAIL bp_order%0d: got v=%b %h want %h", i, out_valid, {out_overflow, out_underflow, out_result}, e); end
            @(negedge clk);
            if (i == 0) begin
                total++; if (in_ready !== 1) begin bad++; $display("FAIL bp_reready: got %b want 1", in_ready); end
                drive(0, 0, 10'd50, 24'h0000CC, {2'b00, 1'b0, 8'd50, 23'h0000CC});
            end else in_valid = 0;
        end
        total++; if (out_valid !== 0) begin bad++; $display("FAIL bp_drain: got %b want 0", out_valid); end
        total++; if (result_count !== 3) begin bad++; $display("FAIL bp_count: got %0d want 3", result_count); end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  ex;
        logic [23:0] m;
        logic        s;
        out_ready = 1;
        clear_flags = 1;
        @(negedge clk);
        clear_flags = 0;
        for (int i = 0; i < 18; i++) begin
            if (i > 0) begin
                e = q.size() ? q.pop_front() : 'x;
                total++; if (!out_valid || {out_overflow, out_underflow, out_result} !== e) begin bad++; $display("FAIL b2b%0d: got v=%b %h want %h", i, out_valid, {out_overflow, out_underflow, out_result}, e); end
            end
            if (i < 17) begin
                s = 1'($urandom_range(0, 1));
                m = 24'($urandom);
                ex = (i == 0) ? 10'd0 : (i == 1) ? 10'd1 : (i == 2) ? 10'd254 : (i == 3) ? 10'd255
                   : (i[0] ? 10'($urandom) : 10'($urandom_range(1, 253)));
                if (i < 4) m[23] = 1'b0;
                drive(0, s, ex, m, model(0, s, ex, m));
            end else in_valid = 0;
            @(negedge clk);
        end
        total++; if (out_valid !== 0) begin bad++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
        total++; if (result_count !== 4'd15) begin bad++; $display("FAIL b2b_saturate: got %0d want 15", result_count); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 0;
        drive(0, 0, 10'd10, 24'h000111, {2'b00, 1'b0, 8'd10, 23'h000111});
        @(negedge clk);
        drive(0, 0, 10'd11, 24'h000222, {2'b00, 1'b0, 8'd11, 23'h000222});
        @(negedge clk);
        in_valid = 0;
        total++; if (in_ready !== 0) begin bad++; $display("FAIL mid_full: got %b want 0", in_ready); end
        rst_n = 0;
        @(negedge clk);
        q.delete();
        total++; if (out_valid !== 0) begin bad++; $display("FAIL mid_valid: got %b want 0", out_valid); end
        total++; if (out_result !== 0) begin bad++; $display("FAIL mid_result: got %h want 0", out_result); end
        total++; if (result_count !== 0) begin bad++; $display("FAIL mid_count: got %0d want 0", result_count); end
        rst_n = 1;
        @(negedge clk);
        total++; if (in_ready !== 1 || out_valid !== 0) begin bad++; $display("FAIL mid_release: got ready=%b valid=%b want 1 0", in_ready, out_valid); end
        out_ready = 1;
        drive(0, 1, 10'd127, 24'h400000, {2'b00, 32'hBFC00000});
        @(negedge clk);
        in_valid = 0;
        e = q.size() ? q.pop_front() : 'x;
        total++; if (!out_valid || {out_overflow, out_underflow, out_result} !== e) begin bad++; $display("FAIL mid_next: got v=%b %h want %h", out_valid, {out_overflow, out_underflow, out_result}, e); end
        @(negedge clk);
        total++; if (out_valid !== 0 || result_count !== 1) begin bad++; $display("FAIL mid_after: got valid=%b count=%0d want 0 1", out_valid, result_count); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_carry();
        test_underflow_zero();
        test_clear();
        test_backpressure();
        test_back_to_back();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
